// File: rtl/t5_pkg.sv
// Shared constants for the t5 pipeline sequencer: opcodes, sequencer states,
// default timing parameters and the NOP instruction injected on bubbles.
package t5_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'h00;
    localparam logic [4:0] OPC_OPIMM  = 5'h04;
    localparam logic [4:0] OPC_BRANCH = 5'h18;
    localparam logic [4:0] OPC_JAL    = 5'h1B;
    localparam logic [4:0] OPC_JALR   = 5'h19;

    // addi x0, x0, 0 : opcode[6:2]=OPC_OPIMM, rd=x0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam int WARM_DEF   = 2;
    localparam int SHADOW_DEF = 2;
    localparam int TMOUT_DEF  = 255;

    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FLSH = 2'd3
    } st_t;

endpackage

// File: rtl/t5_hzd.sv
// Load-use hazard detect: instruction in execute is a load whose rd feeds decode.
// Purely combinational; no state.
module t5_hzd
    import t5_pkg::*;
(
    input  logic [4:0] xopc,
    input  logic [4:0] xrd,
    input  logic [4:0] drs1,
    input  logic [4:0] drs2,
    output logic       hzd
);

    assign hzd = (xopc == OPC_LOAD) && (xrd != 5'd0) && ((xrd == drs1) || (xrd == drs2));

endmodule

// File: rtl/t5_pipe_ctrl.sv
// t5 pipeline sequencer: advance enables, NOP bubbles, branch PC select, data-bus timeout.
// Optional load-use interlock is built when T5_LDUSE_EN is defined.
module t5_pipe_ctrl
    import t5_pkg::*;
#(
    parameter int WARM   = WARM_DEF,
    parameter int SHADOW = SHADOW_DEF,
    parameter int TMOUT  = TMOUT_DEF
) (
    input  logic       sclk,
    input  logic       srst,
    input  logic       iack,
    input  logic       dstb,
    input  logic       dack,
    input  logic       xbra,
    input  logic [4:0] xopc,
    input  logic [4:0] xrd,
    input  logic [4:0] drs1,
    input  logic [4:0] drs2,
    output logic       fena,
    output logic       sena,
    output logic       dnop,
    output logic       fsel,
    output logic       derr
);

    st_t        st;
    logic [1:0] cnt;
    logic [7:0] wcnt;
    logic       derr_q;

    logic dwait;
    logic hold;
    logic adv;
    logic norm;
    logic take;
    logic ldu;
    logic tmo;
    logic hzd;

`ifdef T5_LDUSE_EN
    t5_hzd u_hzd (
        .xopc (xopc),
        .xrd  (xrd),
        .drs1 (drs1),
        .drs2 (drs2),
        .hzd  (hzd)
    );
`else
    logic ldu_unused;
    assign ldu_unused = ^{xopc, xrd, drs1, drs2};
    assign hzd        = 1'b0;
`endif

    always_comb begin
        dwait = dstb & ~dack;
        hold  = ~iack | dwait;
        adv   = ~hold;
        // WAIT behaves like RUN in the cycle the data bus releases
        norm  = (st == ST_RUN) || (st == ST_WAIT);
        take  = adv & xbra & (norm | (st == ST_FLSH));
        ldu   = norm & hzd & ~dwait & ~xbra;
        tmo   = (st == ST_WAIT) & dwait & (wcnt == 8'(TMOUT - 1));
    end

    always_comb begin
        fena = 1'b0;
        sena = 1'b0;
        dnop = 1'b1;
        fsel = 1'b0;
        derr = 1'b0;
        if (!srst) begin
            sena = adv;
            fena = adv & ~ldu;
            dnop = (st == ST_WARM) | (st == ST_FLSH) | take | ldu;
            fsel = take;
            derr = derr_q | tmo;
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            st     <= ST_WARM;
            cnt    <= 2'(WARM);
            wcnt   <= 8'd0;
            derr_q <= 1'b0;
        end else begin
            if (tmo)
                derr_q <= 1'b1;
            case (st)
                ST_WARM: begin
                    if (adv) begin
                        cnt <= cnt - 2'd1;
                        if (cnt == 2'd1)
                            st <= ST_RUN;
                    end
                end
                ST_RUN, ST_WAIT: begin
                    if (dwait) begin
                        if (st == ST_RUN)
                            wcnt <= 8'd0;
                        else if (wcnt != 8'hFF)
                            wcnt <= wcnt + 8'd1;
                        st <= ST_WAIT;
                    end else if (take) begin
                        cnt <= 2'(SHADOW - 1);
                        st  <= ST_FLSH;
                    end else begin
                        st <= ST_RUN;
                    end
                end
                ST_FLSH: begin
                    if (take) begin
                        cnt <= 2'(SHADOW - 1);
                    end else if (adv) begin
                        if (cnt == 2'd0)
                            st <= ST_RUN;
                        else
                            cnt <= cnt - 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t5_pipe_ctrl.sv
// Bench for t5_pipe_ctrl: directed scenarios plus random traffic, scored per cycle
// against a counter-based reference model through an expectation queue.
module tb_t5_pipe_ctrl;

    localparam int WARM   = 2;
    localparam int SHADOW = 2;
    localparam int TMOUT  = 255;
`ifdef T5_LDUSE_EN
    localparam bit LDU = 1'b1;
`else
    localparam bit LDU = 1'b0;
`endif

    logic       sclk;
    logic       srst;
    logic       iack;
    logic       dstb;
    logic       dack;
    logic       xbra;
    logic [4:0] xopc;
    logic [4:0] xrd;
    logic [4:0] drs1;
    logic [4:0] drs2;
    logic       fena;
    logic       sena;
    logic       dnop;
    logic       fsel;
    logic       derr;

    t5_pipe_ctrl #(.WARM(WARM), .SHADOW(SHADOW), .TMOUT(TMOUT)) dut (
        .sclk (sclk),
        .srst (srst),
        .iack (iack),
        .dstb (dstb),
        .dack (dack),
        .xbra (xbra),
        .xopc (xopc),
        .xrd  (xrd),
        .drs1 (drs1),
        .drs2 (drs2),
        .fena (fena),
        .sena (sena),
        .dnop (dnop),
        .fsel (fsel),
        .derr (derr)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic [4:0] v;
        int         ph;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cycn   = 0;
    bit   done   = 1'b0;

    // Reference model: remaining warm-up advances, remaining killed advances,
    // length of the current data stall and the sticky error flag.
    int m_warm  = 0;
    int m_kill  = 0;
    int m_stall = 0;
    bit m_derr  = 1'b0;

    function automatic string pname(input int p);
        case (p)
            0: return "reset";
            1: return "warmup";
            2: return "branch";
            3: return "dwait";
            4: return "timeout";
            5: return "loaduse";
            6: return "collision";
            default: return "random";
        endcase
    endfunction

    task automatic model(output logic [4:0] e);
        bit dw, adv, fe, se, dn, fs, de;
        if (srst) begin
            e       = 5'b00100;
            m_warm  = WARM;
            m_kill  = 0;
            m_stall = 0;
            m_derr  = 1'b0;
        end else begin
            dw  = dstb && !dack;
            adv = iack && !dw;
            fe  = adv;
            se  = adv;
            dn  = 1'b0;
            fs  = 1'b0;
            de  = m_derr;
            if (m_warm > 0) begin
                dn = 1'b1;
                if (adv) m_warm--;
            end else if (m_kill > 0) begin
                dn = 1'b1;
                if (adv && xbra) begin
                    fs     = 1'b1;
                    m_kill = SHADOW;
                end else if (adv) begin
                    m_kill--;
                end
            end else begin
                if (dw) begin
                    m_stall++;
                    if (m_stall > TMOUT) de = 1'b1;
                end else begin
                    m_stall = 0;
                end
                if (adv && xbra) begin
                    fs     = 1'b1;
                    dn     = 1'b1;
                    m_kill = SHADOW;
                end else if (LDU && !dw && !xbra && xopc == 5'h00 && xrd != 5'd0 &&
                             (xrd == drs1 || xrd == drs2)) begin
                    fe = 1'b0;
                    dn = 1'b1;
                end
            end
            m_derr = de;
            e = {fe, se, dn, fs, de};
        end
    endtask

    task automatic cyc(input logic r, input logic i, input logic ds, input logic dk,
                       input logic xb, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] s1, input logic [4:0] s2, input int ph);
        exp_t x;
        @(posedge sclk);
        #1;
        srst = r; iack = i; dstb = ds; dack = dk; xbra = xb;
        xopc = op; xrd = rd; drs1 = s1; drs2 = s2;
        cycn++;
        model(x.v);
        x.ph  = ph;
        x.cyc = cycn;
        q.push_back(x);
    endtask

    task automatic quiet(input int n, input int ph);
        for (int k = 0; k < n; k++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h04, 5'd1, 5'd2, 5'd3, ph);
    endtask

    // Monitor: every falling edge the DUT presents its outputs for the cycle.
    initial begin
        exp_t x;
        logic [4:0] got;
        forever begin
            @(negedge sclk);
            if (q.size() > 0) begin
                x   = q.pop_front();
                got = {fena, sena, dnop, fsel, derr};
                n_chk++;
                if (got === x.v)
                    n_pass++;
                else
                    $display("FAIL %s cycle %0d: fena/sena/dnop/fsel/derr got %b expected %b",
                             pname(x.ph), x.cyc, got, x.v);
            end
        end
    end

    initial begin
        #2_000_000;
        if (!done) begin
            $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed", n_pass, n_chk);
            $fatal(1);
        end
    end

    initial begin
        srst = 1'b1; iack = 1'b0; dstb = 1'b0; dack = 1'b0; xbra = 1'b0;
        xopc = 5'h04; xrd = 5'd0; drs1 = 5'd0; drs2 = 5'd0;

        // reset held with busy-looking inputs: outputs must stay at reset values
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'h00, 5'd5, 5'd5, 5'd5, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h04, 5'd0, 5'd0, 5'd0, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'h18, 5'd1, 5'd2, 5'd3, 0);

        // warm-up: two NOP advances, one frozen cycle in between
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h04, 5'd1, 5'd2, 5'd3, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h04, 5'd1, 5'd2, 5'd3, 1);
        quiet(4, 1);

        // taken branch, then shadow flush
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h18, 5'd0, 5'd2, 5'd3, 2);
        quiet(5, 2);

        // short data wait released by dack
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 5'd7, 5'd2, 5'd3, 3);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 5'd7, 5'd2, 5'd3, 3);
        quiet(3, 3);

        // long data wait: derr rises and sticks until reset
        for (int k = 0; k < 300; k++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 5'd7, 5'd2, 5'd3, 4);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 5'd7, 5'd2, 5'd3, 4);
        quiet(3, 4);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h04, 5'd1, 5'd2, 5'd3, 4);
        quiet(4, 4);

        // load-use candidate, then the same with rd=x0
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 5'd5, 5'd9, 5'd5, 5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h04, 5'd0, 5'd9, 5'd5, 5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 5'd0, 5'd0, 5'd0, 5);
        quiet(2, 5);

        // branch arriving while the data bus stalls
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'h18, 5'd0, 5'd2, 5'd3, 6);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'h18, 5'd0, 5'd2, 5'd3, 6);
        quiet(5, 6);

        // random traffic, occasional long stalls and resets
        for (int k = 0; k < 3000; k++) begin
            logic r, i, ds, dk, xb;
            logic [4:0] op, rd, s1, s2;
            int stall;
            r  = ($urandom_range(199, 0) == 0);
            i  = ($urandom_range(99, 0) < 85);
            ds = ($urandom_range(99, 0) < 25);
            dk = ($urandom_range(99, 0) < 50);
            xb = ($urandom_range(99, 0) < 12);
            op = ($urandom_range(1, 0) == 0) ? 5'h00 : 5'h04;
            rd = 5'($urandom_range(3, 0));
            s1 = 5'($urandom_range(3, 0));
            s2 = 5'($urandom_range(3, 0));
            if ($urandom_range(499, 0) == 0) begin
                stall = $urandom_range(270, 240);
                for (int j = 0; j < stall; j++)
                    cyc(1'b0, 1'b1, 1'b1, 1'b0, xb, op, rd, s1, s2, 7);
            end
            cyc(r, i, ds, dk, xb, op, rd, s1, s2, 7);
        end

        repeat (3) @(negedge sclk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
